// File: rtl/ahb2_apb_bridge.sv
// rtl/ahb2_apb_bridge.sv - AHB2 slave to AMBA2 APB bridge
//
// Converts each accepted AHB NONSEQ/SEQ transfer into one APB SETUP+ACCESS
// pair and holds hreadyo low until the APB access completes. Illegal sizes
// and misaligned addresses get a two-cycle ERROR response, and no APB access
// is issued for them.
//
// Ports:
//   hclk, hreset_n          clock, asynchronous active-low reset
//   hsel, haddr, htrans,    AHB address phase (slave side, after decoder/mux)
//   hwrite, hsize, hburst,
//   hprot, hreadyi
//   hwdata                  AHB write data (data phase)
//   hrdata, hreadyo, hresp  AHB data-phase response (OKAY/ERROR only)
//   paddr, psel, penable,   APB master side
//   pwrite, pwdata, prdata

module ahb2_apb_bridge #(
    parameter int PADDR_W = 16
) (
    input  logic               hclk,
    input  logic               hreset_n,
    input  logic               hsel,
    input  logic [31:0]        haddr,
    input  logic [1:0]         htrans,
    input  logic               hwrite,
    input  logic [2:0]         hsize,
    input  logic [2:0]         hburst,
    input  logic [3:0]         hprot,
    input  logic [31:0]        hwdata,
    input  logic               hreadyi,
    output logic [31:0]        hrdata,
    output logic               hreadyo,
    output logic [1:0]         hresp,
    output logic [PADDR_W-1:0] paddr,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [31:0]        pwdata,
    input  logic [31:0]        prdata
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WCAP,
        S_SETUP,
        S_ACCESS,
        S_RESP,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e               state_q, state_d;
    logic                 hreadyo_q;
    logic [1:0]           hresp_q;
    logic [31:0]          hrdata_q;
    logic                 psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [PADDR_W-1:0]   paddr_q;
    logic [31:0]          pwdata_q;

    logic                 accept_window;
    logic                 accept;
    logic                 size_err;
    logic                 take_legal;

    // hburst/hprot are intentionally ignored; upper haddr bits never reach APB.
    logic                 unused_ok;
    assign unused_ok = &{1'b0, hburst, hprot, haddr};

    // A new address phase can only be sampled while this slave drives
    // hreadyo=1, i.e. in IDLE, RESP and ERR2.
    assign accept_window = (state_q == S_IDLE) || (state_q == S_RESP) || (state_q == S_ERR2);
    assign accept        = hsel && hreadyi && htrans[1];

    always_comb begin
        size_err = 1'b0;
        if (hsize > 3'b010) begin
            size_err = 1'b1;
        end else if (hsize == 3'b001 && haddr[0]) begin
            size_err = 1'b1;
        end else if (hsize == 3'b010 && haddr[1:0] != 2'b00) begin
            size_err = 1'b1;
        end
    end

    assign take_legal = accept_window && accept && !size_err;

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_WCAP:   state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_ERR1:   state_d = S_ERR2;
            default: begin
                if (accept) begin
                    if (size_err) begin
                        state_d = S_ERR1;
                    end else if (hwrite) begin
                        state_d = S_WCAP;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
        endcase
    end

    // Outputs are registered from the next state so they change cleanly with
    // the state register and reset asynchronously with it.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= S_IDLE;
            hreadyo_q <= 1'b1;
            hresp_q   <= RESP_OKAY;
            hrdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            hreadyo_q <= (state_d == S_IDLE) || (state_d == S_RESP) || (state_d == S_ERR2);
            hresp_q   <= ((state_d == S_ERR1) || (state_d == S_ERR2)) ? RESP_ERROR : RESP_OKAY;
            psel_q    <= (state_d == S_SETUP) || (state_d == S_ACCESS);
            penable_q <= (state_d == S_ACCESS);

            // Rejected transfers leave the APB address/direction untouched so
            // the peripheral bus keeps its last legal values.
            if (take_legal) begin
                paddr_q  <= haddr[PADDR_W-1:0];
                pwrite_q <= hwrite;
            end

            // WCAP is the AHB data phase of a write: hwdata is valid here.
            if (state_q == S_WCAP) begin
                pwdata_q <= hwdata;
            end

            if (state_q == S_ACCESS && !pwrite_q) begin
                hrdata_q <= prdata;
            end
        end
    end

    assign hreadyo = hreadyo_q;
    assign hresp   = hresp_q;
    assign hrdata  = hrdata_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_ahb2_apb_bridge.sv
// tb/tb_ahb2_apb_bridge.sv - directed self-checking bench for ahb2_apb_bridge

module tb_ahb2_apb_bridge;

    localparam int PADDR_W = 16;

    logic               hclk;
    logic               hreset_n;
    logic               hsel;
    logic [31:0]        haddr;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [2:0]         hsize;
    logic [2:0]         hburst;
    logic [3:0]         hprot;
    logic [31:0]        hwdata;
    logic               hreadyi;
    logic [31:0]        hrdata;
    logic               hreadyo;
    logic [1:0]         hresp;
    logic [PADDR_W-1:0] paddr;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;

    int checks = 0;
    int errors = 0;

    ahb2_apb_bridge #(.PADDR_W(PADDR_W)) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hprot    (hprot),
        .hwdata   (hwdata),
        .hreadyi  (hreadyi),
        .hrdata   (hrdata),
        .hreadyo  (hreadyo),
        .hresp    (hresp),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then observed 1 ns after the edge.
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // Check the four handshake outputs in one call.
    task automatic chk_bus(input string tag, input logic e_psel, input logic e_pen,
                           input logic e_rdy, input logic [1:0] e_resp);
        chk({tag, ".psel"},    32'(psel),    32'(e_psel));
        chk({tag, ".penable"}, 32'(penable), 32'(e_pen));
        chk({tag, ".hreadyo"}, 32'(hreadyo), 32'(e_rdy));
        chk({tag, ".hresp"},   32'(hresp),   32'(e_resp));
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [1:0] tr);
        hsel   = 1'b1;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = tr;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    initial begin
        hreset_n = 1'b0;
        hsel     = 1'b0;
        haddr    = '0;
        htrans   = 2'b00;
        hwrite   = 1'b0;
        hsize    = 3'b010;
        hburst   = 3'b000;
        hprot    = 4'b0011;
        hwdata   = '0;
        hreadyi  = 1'b1;
        prdata   = '0;

        // Reset state
        repeat (2) @(posedge hclk);
        #1;
        chk_bus("rst", 1'b0, 1'b0, 1'b1, 2'b00);
        chk("rst.hrdata", hrdata, 32'h0);
        chk("rst.paddr",  32'(paddr), 32'h0);
        chk("rst.pwrite", 32'(pwrite), 32'h0);
        chk("rst.pwdata", pwdata, 32'h0);
        hreset_n = 1'b1;
        step();
        chk_bus("idle", 1'b0, 1'b0, 1'b1, 2'b00);

        // Single read
        addr_phase(32'h0000_0124, 1'b0, 3'b010, 2'b10);
        prdata = 32'hCAFE_F00D;
        step();
        bus_idle();
        chk_bus("rd.setup", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("rd.paddr",  32'(paddr), 32'h0124);
        chk("rd.pwrite", 32'(pwrite), 32'h0);
        step();
        chk_bus("rd.access", 1'b1, 1'b1, 1'b0, 2'b00);
        chk("rd.paddr2", 32'(paddr), 32'h0124);
        step();
        chk_bus("rd.resp", 1'b0, 1'b0, 1'b1, 2'b00);
        chk("rd.hrdata", hrdata, 32'hCAFE_F00D);
        prdata = 32'hFFFF_0000;
        step();
        chk_bus("rd.idle", 1'b0, 1'b0, 1'b1, 2'b00);
        chk("rd.hrdata_hold", hrdata, 32'hCAFE_F00D);

        // Single write
        addr_phase(32'h0000_0040, 1'b1, 3'b010, 2'b10);
        step();
        bus_idle();
        hwdata = 32'h1234_5678;
        chk_bus("wr.wcap", 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        hwdata = 32'hDEAD_DEAD;
        chk_bus("wr.setup", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("wr.paddr",  32'(paddr), 32'h0040);
        chk("wr.pwrite", 32'(pwrite), 32'h1);
        chk("wr.pwdata", pwdata, 32'h1234_5678);
        step();
        chk_bus("wr.access", 1'b1, 1'b1, 1'b0, 2'b00);
        chk("wr.pwdata2", pwdata, 32'h1234_5678);
        step();
        chk_bus("wr.resp", 1'b0, 1'b0, 1'b1, 2'b00);
        chk("wr.hrdata_kept", hrdata, 32'hCAFE_F00D);
        step();
        chk_bus("wr.idle", 1'b0, 1'b0, 1'b1, 2'b00);
        chk("wr.pwdata_hold", pwdata, 32'h1234_5678);

        // Back-to-back: read, then SEQ write accepted in the read's RESP cycle
        addr_phase(32'h0000_0200, 1'b0, 3'b010, 2'b10);
        prdata = 32'h0BAD_BEEF;
        step();
        bus_idle();
        chk_bus("b2b.setup1", 1'b1, 1'b0, 1'b0, 2'b00);
        step();
        chk_bus("b2b.access1", 1'b1, 1'b1, 1'b0, 2'b00);
        step();
        addr_phase(32'h0000_0204, 1'b1, 3'b010, 2'b11);
        chk_bus("b2b.resp1", 1'b0, 1'b0, 1'b1, 2'b00);
        chk("b2b.hrdata", hrdata, 32'h0BAD_BEEF);
        step();
        bus_idle();
        hwdata = 32'hA5A5_5A5A;
        chk_bus("b2b.wcap", 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        chk_bus("b2b.setup2", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("b2b.paddr2",  32'(paddr), 32'h0204);
        chk("b2b.pwrite2", 32'(pwrite), 32'h1);
        chk("b2b.pwdata2", pwdata, 32'hA5A5_5A5A);
        step();
        chk_bus("b2b.access2", 1'b1, 1'b1, 1'b0, 2'b00);
        step();
        chk_bus("b2b.resp2", 1'b0, 1'b0, 1'b1, 2'b00);
        step();

        // Errors: oversize, then misaligned word accepted in ERR2
        addr_phase(32'h0000_0000, 1'b0, 3'b011, 2'b10);
        step();
        bus_idle();
        chk_bus("err.a1", 1'b0, 1'b0, 1'b0, 2'b01);
        addr_phase(32'h0000_0002, 1'b1, 3'b010, 2'b10);
        step();
        chk_bus("err.a2", 1'b0, 1'b0, 1'b1, 2'b01);
        step();
        bus_idle();
        chk_bus("err.b1", 1'b0, 1'b0, 1'b0, 2'b01);
        step();
        chk_bus("err.b2", 1'b0, 1'b0, 1'b1, 2'b01);
        step();
        chk_bus("err.idle", 1'b0, 1'b0, 1'b1, 2'b00);
        chk("err.paddr_kept",  32'(paddr), 32'h0204);
        chk("err.pwrite_kept", 32'(pwrite), 32'h1);

        // Legal halfword at haddr[1]=1 is accepted
        addr_phase(32'h0001_0012, 1'b0, 3'b001, 2'b10);
        step();
        bus_idle();
        chk_bus("hw.setup", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("hw.paddr", 32'(paddr), 32'h0012);
        step();
        step();
        chk_bus("hw.resp", 1'b0, 1'b0, 1'b1, 2'b00);
        step();

        // No-transfer cycles
        addr_phase(32'h0000_0300, 1'b0, 3'b010, 2'b01);
        step();
        chk_bus("busy", 1'b0, 1'b0, 1'b1, 2'b00);
        addr_phase(32'h0000_0300, 1'b0, 3'b010, 2'b10);
        hreadyi = 1'b0;
        step();
        chk_bus("nrdy", 1'b0, 1'b0, 1'b1, 2'b00);
        hsel    = 1'b0;
        hreadyi = 1'b1;
        step();
        chk_bus("nsel", 1'b0, 1'b0, 1'b1, 2'b00);
        bus_idle();
        step();
        chk_bus("nx.idle", 1'b0, 1'b0, 1'b1, 2'b00);

        // Reset during ACCESS
        addr_phase(32'h0000_0300, 1'b0, 3'b010, 2'b10);
        prdata = 32'h7777_1111;
        step();
        bus_idle();
        step();
        chk_bus("rma.access", 1'b1, 1'b1, 1'b0, 2'b00);
        hreset_n = 1'b0;
        #1;
        chk_bus("rma.async", 1'b0, 1'b0, 1'b1, 2'b00);
        chk("rma.hrdata", hrdata, 32'h0);
        step();
        hreset_n = 1'b1;
        step();
        chk_bus("rma.idle1", 1'b0, 1'b0, 1'b1, 2'b00);
        step();
        chk_bus("rma.idle2", 1'b0, 1'b0, 1'b1, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb2_apb_bridge.md
Name: ahb2_apb_bridge

Overview:
- AHB2 slave that consumes the AHB slave-side bus (hsel/haddr/htrans/... with hreadyi/hreadyo) and produces AMBA2 APB transfers to a peripheral cluster.
- Sits downstream of the AHB decoder/mux. Converts each accepted NONSEQ/SEQ transfer into one APB SETUP+ACCESS pair and inserts AHB wait states until the APB access is complete.
- Rejects illegal sizes and misaligned addresses with a two-cycle ERROR response; no APB access is issued for them.

Parameters:
- PADDR_W, 16, APB address width; paddr = haddr[PADDR_W-1:0].

Ports:
- hclk, input, 1, clock.
- hreset_n, input, 1, asynchronous active-low reset.
- hsel, input, 1, slave select from decoder.
- haddr, input, 32, AHB address.
- htrans, input, 2, transfer type (IDLE/BUSY/NONSEQ/SEQ).
- hwrite, input, 1, 1 = write.
- hsize, input, 3, transfer size.
- hburst, input, 3, burst type; ignored (each beat handled independently).
- hprot, input, 4, protection; ignored.
- hwdata, input, 32, write data, valid in data phase.
- hreadyi, input, 1, bus-level HREADY.
- hrdata, output, 32, read data.
- hreadyo, output, 1, this slave's HREADY.
- hresp, output, 2, response (OKAY/ERROR only).
- paddr, output, PADDR_W, APB address.
- psel, output, 1, APB select.
- penable, output, 1, APB enable.
- pwrite, output, 1, APB direction.
- pwdata, output, 32, APB write data.
- prdata, input, 32, APB read data.

Behaviour:
- Clocking and reset: single clock hclk. hreset_n is asynchronous, active-low.
- Reset values: state=IDLE, hreadyo=1, hresp=OKAY, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
- Accept condition: hsel & hreadyi & htrans[1] (NONSEQ or SEQ), evaluated only in states IDLE, RESP and ERR2. On accept, register haddr[PADDR_W-1:0], hwrite and hsize.
- IDLE, BUSY, or hsel=0: not accepted. Next state is IDLE, with hreadyo=1 and hresp=OKAY (zero-wait OKAY).
- Error check at accept:
  - hsize > 3'b010 (wider than 32 bits) is an error.
  - hsize=16-bit with haddr[0]=1 is an error.
  - hsize=32-bit with haddr[1:0]!=0 is an error.
  - On error, go to ERR1.
- States and outputs (hreadyo/hresp are values driven during that state):
  - IDLE: hreadyo=1, OKAY.
  - WCAP (write only): hreadyo=0. Capture pwdata<=hwdata; go to SETUP.
  - SETUP: psel=1, penable=0, hreadyo=0; go to ACCESS.
  - ACCESS: psel=1, penable=1, hreadyo=0. If read, hrdata<=prdata at end of cycle. Go to RESP.
  - RESP: psel=0, penable=0, hreadyo=1, OKAY. Next is WCAP/SETUP/ERR1 on a new accept, else IDLE.
  - ERR1: hreadyo=0, hresp=ERROR; go to ERR2.
  - ERR2: hreadyo=1, hresp=ERROR. Next per accept, as in RESP.
- Latency from the address phase cycle to the completing data-phase cycle (inclusive of data phase):
  - Read: SETUP, ACCESS, RESP = 3 cycles (2 wait states).
  - Write: WCAP, SETUP, ACCESS, RESP = 4 cycles (3 wait states).
- Accept sources: from IDLE, the next state follows the accept. Back-to-back transfers are accepted in RESP/ERR2 because hreadyo=1 there; no idle cycle is inserted between APB accesses.
- Stability: paddr, pwrite and pwdata hold stable from SETUP through ACCESS and keep their last values afterwards. hrdata holds its last read value until the next read.
- Sub-word writes: full hwdata is passed on pwdata (AMBA2 APB has no strobes). The peripheral uses paddr/size decode.
- hresp never drives RETRY or SPLIT.
- Reset mid-operation: psel/penable drop immediately and the in-flight transfer is abandoned.

Test Plan:
- Read: NONSEQ read haddr=0x0000_0124, prdata=0xCAFE_F00D.
  - Required: psel high 2 cycles, penable high in the 2nd, paddr=0x0124, pwrite=0.
  - Required: hreadyo low 2 cycles then high with hrdata=0xCAFE_F00D, OKAY.
- Write: NONSEQ write haddr=0x40, hwdata=0x1234_5678.
  - Required: WCAP cycle, then SETUP/ACCESS with pwdata=0x1234_5678, pwrite=1.
  - Required: 3 wait states then OKAY.
- Back-to-back: read then SEQ write accepted in the RESP cycle.
  - Required: second SETUP starts 2 cycles after the first RESP; psel never glitches in the RESP cycle.
- Errors: hsize=3'b011 at 0x0, and hsize=32-bit at 0x2.
  - Required: each gives ERR1 (hreadyo=0, ERROR), then ERR2 (hreadyo=1, ERROR); psel stays 0.
- No-transfer cycles: htrans=BUSY with hsel=1, and htrans=NONSEQ with hreadyi=0.
  - Required: no APB access; hreadyo=1, OKAY.
- Reset mid-access: assert hreset_n=0 during ACCESS.
  - Required: psel=0, penable=0, hreadyo=1 immediately (asynchronous), IDLE after release.
